// File: rtl/fix_complex_div_pkg.sv
// Shared constants for the fixed-point complex divider: FSM state encodings.
package fix_complex_div_pkg;

    localparam int unsigned ST_W = 3;

    localparam logic [ST_W-1:0] ST_IDLE = 3'd0;
    localparam logic [ST_W-1:0] ST_MUL  = 3'd1;
    localparam logic [ST_W-1:0] ST_DIV  = 3'd2;
    localparam logic [ST_W-1:0] ST_FIX  = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE = 3'd4;

endpackage

// File: rtl/fix_udiv_seq.sv
// Unsigned radix-2 restoring divider: loads num/den, then yields one quotient bit
// (MSB first) per step; after qw steps o_quo holds floor(num / den) if it fits in qw bits.
module fix_udiv_seq #(
    parameter int unsigned nw = 41,
    parameter int unsigned dw = 33,
    parameter int unsigned qw = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_load,
    input  logic          i_step,
    input  logic [nw-1:0] i_num,
    input  logic [dw-1:0] i_den,
    output logic [qw-1:0] o_quo
);

    localparam int unsigned HW = nw - qw;
    localparam int unsigned RW = ((HW > dw) ? HW : dw) + 1;

    logic [RW-1:0] r_rem;
    logic [qw-1:0] r_sh;
    logic [dw-1:0] r_den;

    logic [RW-1:0] w_trial;
    logic [RW-1:0] w_den_x;
    logic          w_ge;

    // Bring down the next dividend bit and try the subtraction.
    always_comb begin
        w_trial = {r_rem[RW-2:0], r_sh[qw-1]};
        w_den_x = RW'(r_den);
        w_ge    = (w_trial >= w_den_x);
    end

    // r_sh starts as the low dividend bits and fills with quotient bits from the right.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rem <= '0;
            r_sh  <= '0;
            r_den <= '0;
        end else if (i_load) begin
            r_rem <= RW'(i_num[nw-1:qw]);
            r_sh  <= i_num[qw-1:0];
            r_den <= i_den;
        end else if (i_step) begin
            r_rem <= w_ge ? (w_trial - w_den_x) : w_trial;
            r_sh  <= {r_sh[qw-2:0], w_ge};
        end
    end

    assign o_quo = r_sh;

endmodule

// File: rtl/fix_complex_div.sv
// Sequential fixed-point complex divider c = a*conj(b)/|b|^2 with {im, re} packing,
// truncation toward zero, per-half saturation and a divide-by-zero flag.
module fix_complex_div
    import fix_complex_div_pkg::*;
#(
    parameter int unsigned ws = 16,
    parameter int unsigned dp = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [2*ws-1:0] a,
    input  logic [2*ws-1:0] b,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [2*ws-1:0] c,
    output logic          div0,
    output logic          ovf
);

    localparam int unsigned PW = 2*ws + 1;
    localparam int unsigned NW = PW + dp;
    localparam int unsigned QW = ws - 1;
    localparam int unsigned OW = PW + ws;
    localparam int unsigned CW = $clog2(ws);

    logic [ST_W-1:0] r_state;
    logic [ST_W-1:0] w_state_nx;
    logic            w_load;
    logic            w_step;

    logic [2*ws-1:0] r_a;
    logic [2*ws-1:0] r_b;
    logic [CW-1:0]   r_cnt;

    logic            r_nr_neg;
    logic            r_ni_neg;
    logic            r_nr_ovf;
    logic            r_ni_ovf;
    logic            r_div0_f;

    logic [2*ws-1:0] r_c;
    logic            r_div0;
    logic            r_ovf;
    logic            r_out_valid;
    logic            r_in_ready;

    logic signed [ws-1:0] w_ar;
    logic signed [ws-1:0] w_ai;
    logic signed [ws-1:0] w_br;
    logic signed [ws-1:0] w_bi;
    logic signed [PW-1:0] w_arx;
    logic signed [PW-1:0] w_aix;
    logic signed [PW-1:0] w_brx;
    logic signed [PW-1:0] w_bix;
    logic signed [PW-1:0] w_nr;
    logic signed [PW-1:0] w_ni;
    logic [PW-1:0]        w_den;
    logic [PW-1:0]        w_nr_mag;
    logic [PW-1:0]        w_ni_mag;
    logic                 w_nr_ovf;
    logic                 w_ni_ovf;
    logic [QW-1:0]        w_quo_re;
    logic [QW-1:0]        w_quo_im;

    // Apply sign / saturation to one quotient magnitude.
    function automatic logic [ws-1:0] fix_half(input logic neg, input logic sat,
                                               input logic [QW-1:0] q);
        logic [ws-1:0] m;
        m = {1'b0, q};
        if (sat)
            return neg ? {1'b1, {QW{1'b0}}} : {1'b0, {QW{1'b1}}};
        return neg ? -m : m;
    endfunction

    // Full-precision numerators, denominator and overflow pre-check from captured operands.
    always_comb begin
        w_ar     = signed'(r_a[ws-1:0]);
        w_ai     = signed'(r_a[2*ws-1:ws]);
        w_br     = signed'(r_b[ws-1:0]);
        w_bi     = signed'(r_b[2*ws-1:ws]);
        w_arx    = PW'(w_ar);
        w_aix    = PW'(w_ai);
        w_brx    = PW'(w_br);
        w_bix    = PW'(w_bi);
        w_nr     = w_arx*w_brx + w_aix*w_bix;
        w_ni     = w_aix*w_brx - w_arx*w_bix;
        w_den    = w_brx*w_brx + w_bix*w_bix;
        w_nr_mag = w_nr[PW-1] ? -w_nr : w_nr;
        w_ni_mag = w_ni[PW-1] ? -w_ni : w_ni;
        w_nr_ovf = (OW'(w_nr_mag) >= (OW'(w_den) << (ws-1-dp)));
        w_ni_ovf = (OW'(w_ni_mag) >= (OW'(w_den) << (ws-1-dp)));
    end

    fix_udiv_seq #(.nw(NW), .dw(PW), .qw(QW)) u_div_re (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_num  (NW'(w_nr_mag) << dp),
        .i_den  (w_den),
        .o_quo  (w_quo_re)
    );

    fix_udiv_seq #(.nw(NW), .dw(PW), .qw(QW)) u_div_im (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_num  (NW'(w_ni_mag) << dp),
        .i_den  (w_den),
        .o_quo  (w_quo_im)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_load     = 1'b0;
        w_step     = 1'b0;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_nx = ST_MUL;
            ST_MUL: begin
                w_load     = 1'b1;
                w_state_nx = ST_DIV;
            end
            ST_DIV: begin
                w_step = 1'b1;
                if (r_cnt == '0) w_state_nx = ST_FIX;
            end
            ST_FIX:  w_state_nx = ST_DONE;
            ST_DONE: if (out_ready) w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a         <= '0;
            r_b         <= '0;
            r_cnt       <= '0;
            r_nr_neg    <= 1'b0;
            r_ni_neg    <= 1'b0;
            r_nr_ovf    <= 1'b0;
            r_ni_ovf    <= 1'b0;
            r_div0_f    <= 1'b0;
            r_c         <= '0;
            r_div0      <= 1'b0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: if (in_valid) begin
                    r_a <= a;
                    r_b <= b;
                end
                ST_MUL: begin
                    r_nr_neg <= w_nr[PW-1];
                    r_ni_neg <= w_ni[PW-1];
                    r_nr_ovf <= w_nr_ovf;
                    r_ni_ovf <= w_ni_ovf;
                    r_div0_f <= (w_den == '0);
                    r_cnt    <= CW'(ws-2);
                end
                ST_DIV: r_cnt <= r_cnt - CW'(1);
                ST_FIX: begin
                    r_c    <= r_div0_f ? '0 :
                              {fix_half(r_ni_neg, r_ni_ovf, w_quo_im),
                               fix_half(r_nr_neg, r_nr_ovf, w_quo_re)};
                    r_div0 <= r_div0_f;
                    r_ovf  <= !r_div0_f && (r_nr_ovf || r_ni_ovf);
                end
                default: ;
            endcase
            r_in_ready  <= (w_state_nx == ST_IDLE);
            r_out_valid <= (w_state_nx == ST_DONE);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign c         = r_c;
    assign div0      = r_div0;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_fix_complex_div.sv
// Self-checking bench for fix_complex_div (ws=16, dp=8): directed cases plus a
// random back-to-back run against a bit-exact model, results matched through a queue.
module tb_fix_complex_div;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] c;
    logic        div0;
    logic        ovf;

    int          n_assert = 0;
    int          n_fail = 0;
    logic [33:0] sb[$];
    logic        rnd_rdy = 1'b0;
    logic        rdy_dir = 1'b1;

    fix_complex_div #(.ws(16), .dp(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .c         (c),
        .div0      (div0),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #2;
        out_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : rdy_dir;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] half(input longint n, input longint d, output logic o);
        longint mag, q;
        mag = (n < 0) ? -n : n;
        q   = (mag * 256) / d;
        o   = (q >= 32768);
        if (o) return (n < 0) ? 16'h8000 : 16'h7FFF;
        return (n < 0) ? 16'(-q) : 16'(q);
    endfunction

    // Expected {c, div0, ovf}.
    function automatic logic [33:0] model(input logic [31:0] av, input logic [31:0] bv);
        longint ar, ai, br, bi, nr, ni, den;
        logic [15:0] re, im;
        logic o1, o2;
        ar  = longint'($signed(av[15:0]));
        ai  = longint'($signed(av[31:16]));
        br  = longint'($signed(bv[15:0]));
        bi  = longint'($signed(bv[31:16]));
        nr  = ar*br + ai*bi;
        ni  = ai*br - ar*bi;
        den = br*br + bi*bi;
        if (den == 0) return {32'h0, 1'b1, 1'b0};
        re = half(nr, den, o1);
        im = half(ni, den, o2);
        return {im, re, 1'b0, o1 | o2};
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) chk("sb_underflow", 64'(sb.size()), 64'd1);
            else chk("result", 64'({c, div0, ovf}), 64'(sb.pop_front()));
        end
    end

    // Offer one operand pair; on acceptance (edge 0) queue its expected result.
    task automatic send(input logic [31:0] av, input logic [31:0] bv, input logic [33:0] exp);
        logic ok;
        ok = 1'b0;
        a = av; b = bv; in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            chk("accept_timeout", 64'(ok), 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        sb.push_back(exp);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin lat = k; break; end
        end
    endtask

    task automatic directed(input string tag, input logic [31:0] av, input logic [31:0] bv,
                            input logic [31:0] ec, input logic ed, input logic eo);
        int lat;
        send(av, bv, {ec, ed, eo});
        wait_out(lat);
        chk({tag, "_latency"}, 64'(lat), 64'd17);
        @(negedge clk);
    endtask

    initial begin
        int lat;
        logic [31:0] ra, rb;
        logic [31:0] hold_c;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_c", 64'({c, div0, ovf}), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        directed("t1_j",     32'h0100_0100, 32'hFF00_0100, 32'h0100_0000, 1'b0, 1'b0);
        directed("t2_third", 32'h0000_0100, 32'h0000_0300, 32'h0000_0055, 1'b0, 1'b0);
        directed("t2_neg",   32'h0000_FF00, 32'h0000_0300, 32'h0000_FFAB, 1'b0, 1'b0);
        directed("t3_div0",  32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0);
        directed("t4_satp",  32'h0000_6400, 32'h0000_0080, 32'h0000_7FFF, 1'b0, 1'b1);
        directed("t4_satn",  32'h0000_9C00, 32'h0000_0080, 32'h0000_8000, 1'b0, 1'b1);

        // Back-pressure: result held, input side closed, stray in_valid ignored.
        rdy_dir = 1'b0;
        send(32'h0000_0100, 32'h0000_0300, {32'h0000_0055, 1'b0, 1'b0});
        wait_out(lat);
        chk("bp_latency", 64'(lat), 64'd17);
        hold_c = 32'h0000_0055;
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin a = 32'h0100_0100; b = 32'h0000_0100; in_valid = 1'b1; end
            @(posedge clk); #1;
            in_valid = 1'b0;
            chk("bp_c_stable", 64'(c), 64'(hold_c));
            chk("bp_out_valid", 64'(out_valid), 64'd1);
            chk("bp_in_ready", 64'(in_ready), 64'd0);
        end
        rdy_dir = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("bp_drained", 64'(sb.size()), 64'd0);
        chk("bp_ready_again", 64'(in_ready), 64'd1);
        repeat (25) @(posedge clk);
        #1;
        chk("bp_pulse_ignored", 64'(out_valid), 64'd0);

        // Reset in the middle of DIV.
        send(32'h1234_5678, 32'h0100_0300, model(32'h1234_5678, 32'h0100_0300));
        repeat (5) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_c", 64'(c), 64'd0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        chk("post_rst_out_valid", 64'(out_valid), 64'd0);
        directed("post_rst_t1", 32'h0100_0100, 32'hFF00_0100, 32'h0100_0000, 1'b0, 1'b0);

        // Random back-to-back traffic with random downstream stalls.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            int mode;
            mode = $urandom_range(0, 9);
            ra = $urandom;
            rb = $urandom;
            if (mode == 0) rb = 32'h0;
            else if (mode == 1) rb = {{8{rb[23]}}, rb[23:16], {8{rb[7]}}, rb[7:0]};
            else if (mode == 2) ra = {{8{ra[23]}}, ra[23:16], {8{ra[7]}}, ra[7:0]};
            send(ra, rb, model(ra, rb));
        end
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            if (sb.size() == 0) break;
        end
        rnd_rdy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_drain", 64'(sb.size()), 64'd0);
        chk("final_idle", 64'(in_ready), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
